// File: rtl/arb_requester_if.sv
// rtl/arb_requester_if.sv - command, status and request/grant bundle for arb_requester
interface arb_requester_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       cmd_valid;
  logic [1:0]       cmd_ready;
  logic [LEN_W-1:0] cmd_len0;
  logic [LEN_W-1:0] cmd_len1;
  logic [1:0]       request;
  logic [1:0]       grant;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       err_timeout;

  // master: traffic source plus arbiter side; slave: the requester block
  modport master (
    output cmd_valid, cmd_len0, cmd_len1, grant,
    input  cmd_ready, request, busy, done, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_len0, cmd_len1, grant,
    output cmd_ready, request, busy, done, err_timeout
  );
endinterface

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - two-channel burst requester for a registered fixed-priority arbiter
// Optional WAIT timeout abort enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  arb_requester_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;
  localparam logic [1:0] ST_COOL = 2'd3;

  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [1:0]       state;
    logic [LEN_W:0]   remaining;
    logic [LEN_W-1:0] len;
    logic             grant;
    logic             last_beat;
    logic             timeout_hit;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    assign len       = (i == 0) ? bus.cmd_len0 : bus.cmd_len1;
    assign grant     = bus.grant[i];
    assign last_beat = (remaining == REM_ONE);

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    logic [WCNT_W-1:0] wcnt;

    // Counts only an unbroken run of ungranted WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wcnt <= '0;
      end else if ((state == ST_WAIT) && !grant && !timeout_hit) begin
        wcnt <= wcnt + WCNT_W'(1);
      end else begin
        wcnt <= '0;
      end
    end

    assign timeout_hit = (state == ST_WAIT) && !grant &&
                         (wcnt == WCNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= ST_IDLE;
        remaining <= '0;
        req_q     <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (bus.cmd_valid[i]) begin
              // A zero length field encodes the full 2**LEN_W beats.
              remaining <= {(len == '0), len};
              state     <= ST_WAIT;
              req_q     <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (grant) begin
              remaining <= remaining - REM_ONE;
              if (last_beat) begin
                state  <= ST_COOL;
                req_q  <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state  <= ST_OWN;
                busy_q <= 1'b1;
              end
            end else if (timeout_hit) begin
              remaining <= '0;
              state     <= ST_COOL;
              req_q     <= 1'b0;
              err_q     <= 1'b1;
            end
          end
          ST_OWN: begin
            if (grant) begin
              remaining <= remaining - REM_ONE;
              if (last_beat) begin
                state  <= ST_COOL;
                req_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              // Preempted: keep the remaining count and re-arbitrate.
              state  <= ST_WAIT;
              busy_q <= 1'b0;
            end
          end
          ST_COOL: begin
            // One idle cycle so the arbiter's stale grant is never counted.
            state <= ST_IDLE;
          end
          default: begin
            state     <= ST_IDLE;
            remaining <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end

    assign bus.cmd_ready[i]   = (state == ST_IDLE);
    assign bus.request[i]     = req_q;
    assign bus.busy[i]        = busy_q;
    assign bus.done[i]        = done_q;
    assign bus.err_timeout[i] = err_q;
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - randomized and directed bench for arb_requester against a beat-count model
module tb_arb_requester;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int M_ARB  = 0;
  localparam int M_STUB = 1;
  localparam int M_RAND = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   mode;

  arb_requester_if #(.LEN_W(LEN_W)) bus ();

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: beats still owed, cooldown pending, currently holding grant, ungranted wait run.
  int   pend  [2];
  int   cool  [2];
  int   ung   [2];
  bit   owned [2];
  logic [1:0] exp_req, exp_busy, exp_done, exp_err, exp_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      pend[c] = 0; cool[c] = 0; ung[c] = 0; owned[c] = 1'b0;
    end
    exp_req = '0; exp_busy = '0; exp_done = '0; exp_err = '0; exp_rdy = 2'b11;
  endfunction

  function automatic void model_step(input logic [1:0] val, input logic [LEN_W-1:0] l0,
                                     input logic [LEN_W-1:0] l1, input logic [1:0] gnt);
    for (int c = 0; c < 2; c++) begin
      int len;
      len = (c == 0) ? int'(l0) : int'(l1);
      exp_done[c] = 1'b0;
      exp_err[c]  = 1'b0;
      if (cool[c] != 0) begin
        cool[c] = 0;
      end else if (pend[c] == 0) begin
        if (val[c]) begin
          pend[c] = (len == 0) ? (1 << LEN_W) : len;
          owned[c] = 1'b0;
          ung[c] = 0;
        end
      end else if (gnt[c]) begin
        pend[c]--;
        ung[c] = 0;
        if (pend[c] == 0) begin
          exp_done[c] = 1'b1; cool[c] = 1; owned[c] = 1'b0;
        end else begin
          owned[c] = 1'b1;
        end
      end else if (owned[c]) begin
        owned[c] = 1'b0;
        ung[c] = 0;
      end else begin
        ung[c]++;
        if (TIMEOUT_ON && ung[c] == TIMEOUT) begin
          pend[c] = 0; cool[c] = 1; exp_err[c] = 1'b1; ung[c] = 0;
        end
      end
      exp_req[c]  = (pend[c] != 0);
      exp_busy[c] = owned[c];
      exp_rdy[c]  = (pend[c] == 0) && (cool[c] == 0);
    end
  endfunction

  // One clock: model consumes the pre-edge inputs, the arbiter stand-in registers a new grant.
  task automatic tick();
    logic [1:0] req_b, val_b, gnt_b;
    logic [LEN_W-1:0] l0, l1;
    req_b = bus.request; val_b = bus.cmd_valid; gnt_b = bus.grant;
    l0 = bus.cmd_len0; l1 = bus.cmd_len1;
    model_step(val_b, l0, l1, gnt_b);
    @(posedge clk);
    #1;
    case (mode)
      M_ARB:   bus.grant = req_b[0] ? 2'b01 : (req_b[1] ? 2'b10 : 2'b00);
      M_STUB:  bus.grant = 2'b00;
      default: bus.grant = 2'($urandom);
    endcase
    check("request", bus.request, exp_req);
    check("busy", bus.busy, exp_busy);
    check("done", bus.done, exp_done);
    check("err_timeout", bus.err_timeout, exp_err);
    check("cmd_ready", bus.cmd_ready, exp_rdy);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    bus.cmd_valid = 2'b00;
    bus.grant = 2'b00;
    #1;
    check("rst_request", bus.request, 2'b00);
    check("rst_busy", bus.busy, 2'b00);
    check("rst_done", bus.done, 2'b00);
    check("rst_cmd_ready", bus.cmd_ready, 2'b11);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit t1_req  [1:5];
    bit t1_done [1:5];
    bit t1_rdy  [1:5];
    int cnt, cnt2;

    n_cmp = 0; n_err = 0; mode = M_ARB;
    rst = 1'b1;
    bus.cmd_valid = 2'b00; bus.cmd_len0 = '0; bus.cmd_len1 = '0; bus.grant = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_request", bus.request, 2'b00);
    check("init_busy", bus.busy, 2'b00);
    check("init_done", bus.done, 2'b00);
    check("init_err", bus.err_timeout, 2'b00);
    check("init_cmd_ready", bus.cmd_ready, 2'b11);
    rst = 1'b0;

    // Uncontested 3-beat burst on channel 0 with the arbiter in the loop.
    t1_req  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t1_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t1_rdy  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.cmd_len0 = 4'd3; bus.cmd_valid = 2'b01;
    tick();
    bus.cmd_valid = 2'b00;
    check("t1_req_e0", bus.request[0], 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1_req", bus.request[0], t1_req[k]);
      check("t1_done", bus.done[0], t1_done[k]);
      check("t1_ready", bus.cmd_ready[0], t1_rdy[k]);
    end
    check("t1_grant_e5", bus.grant[0], 1'b0);

    // Channel 1 preempted by channel 0, then resumes for its remaining beats.
    cnt = 0;
    bus.cmd_len1 = 4'd4; bus.cmd_len0 = 4'd2;
    for (int e = 0; e <= 10; e++) begin
      bus.cmd_valid = (e == 0) ? 2'b10 : ((e == 2) ? 2'b01 : 2'b00);
      tick();
      bus.cmd_valid = 2'b00;
      cnt += int'(bus.done[1]);
      if (e == 2) check("t2_busy1_owned", bus.busy[1], 1'b1);
      if (e == 4) check("t2_busy1_preempt", bus.busy[1], 1'b0);
      if (e == 5) check("t2_done0", bus.done[0], 1'b1);
      if (e == 8) check("t2_done1", bus.done[1], 1'b1);
    end
    check("t2_done1_count", cnt, 1);

    // Length field 0 means 16 beats.
    cnt = 0;
    bus.cmd_len0 = 4'd0; bus.cmd_valid = 2'b01;
    tick();
    bus.cmd_valid = 2'b00;
    for (int k = 1; k <= 18; k++) begin
      tick();
      cnt += int'(bus.done[0]);
      if (k == 16) check("t3_done_early", bus.done[0], 1'b0);
      if (k == 17) check("t3_done_16beats", bus.done[0], 1'b1);
    end
    check("t3_done_count", cnt, 1);

    // Grant stuck low.
    mode = M_STUB; bus.grant = 2'b00;
    bus.cmd_len1 = 4'd5; bus.cmd_valid = 2'b10;
    tick();
    bus.cmd_valid = 2'b00;
    if (TIMEOUT_ON) begin
      for (int k = 1; k <= TIMEOUT + 2; k++) begin
        tick();
        if (k == TIMEOUT - 1) check("t4_err_early", bus.err_timeout[1], 1'b0);
        if (k == TIMEOUT) begin
          check("t4_err", bus.err_timeout[1], 1'b1);
          check("t4_req_drop", bus.request[1], 1'b0);
          check("t4_no_done", bus.done[1], 1'b0);
        end
      end
    end else begin
      cnt = 0; cnt2 = 0;
      for (int k = 1; k <= 100; k++) begin
        tick();
        cnt  += int'(bus.request[1]);
        cnt2 += int'(bus.err_timeout[1]);
      end
      check("t4_req_held", cnt, 100);
      check("t4_no_err", cnt2, 0);
      do_reset();
    end

    // Asynchronous reset in the middle of an owned burst.
    mode = M_ARB;
    bus.cmd_len0 = 4'd4; bus.cmd_valid = 2'b01;
    tick();
    bus.cmd_valid = 2'b00;
    repeat (3) tick();
    check("t5_busy_before_rst", bus.busy[0], 1'b1);
    do_reset();
    check("t5_ready_after", bus.cmd_ready, 2'b11);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      cnt += int'(bus.done[0]);
    end
    check("t5_no_done", cnt, 0);

    // Back-to-back single-beat bursts with cmd_valid held high.
    cnt = 0;
    bus.cmd_len0 = 4'd1; bus.cmd_valid = 2'b01;
    for (int k = 0; k < 16; k++) begin
      tick();
      cnt += int'(bus.done[0]);
    end
    bus.cmd_valid = 2'b00;
    check("t6_done_count", cnt, 4);
    repeat (4) tick();

    // Random traffic, first through the arbiter, then with arbitrary grants.
    for (int k = 0; k < 600; k++) begin
      mode = (k < 300) ? M_ARB : M_RAND;
      bus.cmd_valid = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      bus.cmd_len0 = LEN_W'($urandom);
      bus.cmd_len1 = LEN_W'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Two-channel client for the 2-bit request/grant arbiter.
- Accepts per-channel burst commands and drives request[i] until the burst has consumed its granted beats.
- Tolerates the arbiter's one-cycle registered grant latency and fixed priority (channel 0 wins), including preemption of channel 1 mid-burst.
- Sits between traffic sources and the arbiter's request/grant pins.

Parameters:
- LEN_W, 4, width of the burst-length field; cmd_len=0 means 2**LEN_W beats.
- TIMEOUT, 15, consecutive ungranted WAIT cycles before abort. Used only when ARB_REQ_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  2  per-channel command strobe.
- cmd_ready  output  2  per-channel; high only when the channel is in IDLE.
- cmd_len0  input  LEN_W  channel 0 burst length.
- cmd_len1  input  LEN_W  channel 1 burst length.
- request  output  2  registered request to the arbiter.
- grant  input  2  grant from the arbiter.
- busy  output  2  registered; channel is in OWN.
- done  output  2  registered one-cycle pulse; burst completed.
- err_timeout  output  2  registered one-cycle pulse; burst aborted.

Behaviour:
- Two identical, independent channel FSMs. States: IDLE, WAIT, OWN, COOL.
- Reset (asynchronous, effective while rst=1):
  - all channels to IDLE; request, busy, done, err_timeout = 0; remaining counters = 0.
  - cmd_ready is decoded from state, so it reads 1 during reset, but no command is accepted while rst=1.
- IDLE:
  - request=0; grant is ignored.
  - cmd_valid[i]&cmd_ready[i] at a posedge: load remaining = cmd_len (0 loads 2**LEN_W), go to WAIT.
- WAIT:
  - request=1.
  - Posedge with grant[i]=1 counts one beat (remaining-1). Go to OWN, or to COOL if remaining was 1.
- OWN:
  - request=1, busy=1.
  - Each posedge with grant[i]=1 counts one beat.
  - When remaining goes 1->0: go to COOL; done[i]=1 for the following cycle; request drops at the same edge.
  - Posedge with grant[i]=0 (preempted): go to WAIT; remaining is preserved and no beat is counted.
- COOL:
  - request=0, cmd_ready=0, for exactly one cycle. This lets the arbiter's stale grant clear.
  - Then go to IDLE. A grant seen in COOL or IDLE is never counted.
- Timing for an uncontested burst of L beats accepted at edge N:
  - request high after N.
  - Beats counted at edges N+2 .. N+1+L.
  - request low and done high after N+1+L.
  - cmd_ready high after N+2+L.
- Simultaneous commands on both channels are accepted in the same cycle.
- Beat totals are exact under any preemption pattern: total counted beats per burst = programmed length.
- Counters are LEN_W+1 bits wide so that 2**LEN_W is representable.

Optional Feature:
- Macro ARB_REQ_TIMEOUT_EN.
- Defined:
  - a per-channel wait counter counts consecutive WAIT cycles with grant[i]=0.
  - It clears on any granted cycle and on leaving WAIT.
  - On reaching TIMEOUT: go to COOL, discard remaining, request low, err_timeout[i]=1 for one cycle, done not asserted.
- Not defined: err_timeout is tied to 0 and WAIT persists indefinitely.

Test Plan:
- Ch0, cmd_len0=3, accepted edge 0, with the arbiter in the loop:
  - request[0] high over edges 1-4.
  - Beats at edges 2,3,4.
  - done[0] pulses after edge 4.
  - grant[0] low after edge 5.
  - cmd_ready[0] high after edge 5.
- Ch1, cmd_len1=4, reaches OWN; ch0, cmd_len0=2, issued during ch1's second owned beat:
  - busy[1] drops and ch1 returns to WAIT.
  - ch0 completes 2 beats.
  - ch1 resumes and counts exactly 2 more beats; done[1] pulses once.
- cmd_len0=0 with LEN_W=4 and an uncontested grant: exactly 16 beats, then done[0].
- Grant held low (arbiter stubbed), ch1 cmd_len1=5, macro defined, TIMEOUT=15:
  - err_timeout[1] pulses after the 15th ungranted cycle; request[1] falls; done[1] stays 0.
  - Same stimulus without the macro: request[1] stays high for 100 cycles and err_timeout stays 0.
- rst pulsed asynchronously mid-OWN (ch0 remaining=2):
  - request, busy, done = 0 immediately.
  - After release: IDLE, cmd_ready=2'b11, no done pulse for the aborted burst.
- Back-to-back: cmd_valid[0] held high with len 1:
  - consecutive bursts are separated by the COOL cycle.
  - one done per burst; no extra beats counted from stale grants.
